instruction_fetch_queue: RTL and testbench

//  Front end feeding the core's dispatch logic: fetches 32-byte lines from the memory access controller,

---
 rtl/instruction_fetch_queue_pkg.sv | 20 ++
 rtl/instruction_fetch_queue_if.sv | 18 +
 rtl/ifq_ring_buffer.sv | 52 +++++
 rtl/instruction_fetch_queue.sv | 118 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instruction_fetch_queue_pkg;

   localparam int unsigned LINE_BYTES     = 32;
   localparam int unsigned INST_BYTES     = 4;
   localparam int unsigned WORDS_PER_LINE = LINE_BYTES / INST_BYTES;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } queued_instruction;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DROP
   } ifq_state_e;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Memory line request/response bus between the fetch queue (master) and memory (slave).
interface instruction_fetch_queue_if;
   logic         mem_req_v;
   logic [31:0]  mem_req_addr;
   logic         mem_req_rdy;
   logic         mem_rsp_v;
   logic [255:0] mem_rsp_dat;

   modport master (
      output mem_req_v, mem_req_addr,
      input  mem_req_rdy, mem_rsp_v, mem_rsp_dat
   );

   modport slave (
      input  mem_req_v, mem_req_addr,
      output mem_req_rdy, mem_rsp_v, mem_rsp_dat
   );
endinterface

// File: rtl/ifq_ring_buffer.sv
// Ring buffer of queued instructions: up to one full line written per cycle, single pop,
// synchronous clear. Pointers carry one extra wrap bit so count = wr_ptr - rd_ptr.
module ifq_ring_buffer
   import instruction_fetch_queue_pkg::*;
#(
   parameter int unsigned QUEUE_LEN = 16,
   localparam int unsigned PW = $clog2(QUEUE_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [3:0]        wr_n,
   input  queued_instruction wr_data [WORDS_PER_LINE],
   input  logic              pop,
   output queued_instruction head,
   output logic [PW:0]       count,
   output logic [PW:0]       free
);

   queued_instruction mem [QUEUE_LEN];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic        do_pop;

   assign count  = wr_ptr - rd_ptr;
   assign free   = (PW+1)'(QUEUE_LEN) - count;
   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + (PW+1)'(wr_n);
         if (do_pop) rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // Storage needs no reset: head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (!clr) begin
         for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
            if (k < 32'(wr_n)) mem[wr_ptr[PW-1:0] + PW'(k)] <= wr_data[k];
         end
      end
   end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: fetches 32-byte lines, splits them into words and queues them for dispatch.
// Optional IFQ_PERF_CNT_EN adds flush/stall performance counters.
module instruction_fetch_queue
   import instruction_fetch_queue_pkg::*;
#(
   parameter int unsigned QUEUE_LEN = 16
) (
   input  logic        cclk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        mdfy_pc,
   output logic [63:0] curr_inst,
   output logic        inst_pres,
   input  logic        rq_nxt_inst,
`ifdef IFQ_PERF_CNT_EN
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   instruction_fetch_queue_if.master mem
);

   localparam int unsigned PW = $clog2(QUEUE_LEN);

   ifq_state_e        state, state_n;
   logic [31:0]       fetch_pc, fetch_pc_n;
   logic [31:0]       line_addr;
   logic [3:0]        words_in_line;
   logic [3:0]        wr_n;
   logic              clr;
   logic              pop;
   queued_instruction wr_data [WORDS_PER_LINE];
   queued_instruction head;
   logic [PW:0]       count, free;
   logic              unused_lsbs;

   assign unused_lsbs   = ^{pc[1:0], fetch_pc[1:0]};
   assign line_addr     = {fetch_pc[31:5], 5'b0};
   assign words_in_line = 4'd8 - {1'b0, fetch_pc[4:2]};

   assign inst_pres        = (count != '0);
   assign curr_inst        = inst_pres ? head : '0;
   assign pop              = rq_nxt_inst && inst_pres && !mdfy_pc;
   assign mem.mem_req_v    = (state == S_REQ);
   assign mem.mem_req_addr = mem.mem_req_v ? line_addr : '0;

   // Word k of the write burst is line word fetch_pc[4:2]+k; entries past the line end are unused.
   always_comb begin
      for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
         wr_data[k].addr = line_addr + 32'(INST_BYTES * ((k + 32'(fetch_pc[4:2])) % WORDS_PER_LINE));
         wr_data[k].inst = mem.mem_rsp_dat[32 * ((k + 32'(fetch_pc[4:2])) % WORDS_PER_LINE) +: 32];
      end
   end

   always_comb begin
      state_n    = state;
      fetch_pc_n = fetch_pc;
      wr_n       = '0;
      clr        = 1'b0;
      case (state)
         S_IDLE: if (32'(free) >= 32'(words_in_line)) state_n = S_REQ;
         S_REQ:  if (mem.mem_req_rdy) state_n = S_WAIT;
         S_WAIT: if (mem.mem_rsp_v) begin
            wr_n       = words_in_line;
            fetch_pc_n = line_addr + 32'(LINE_BYTES);
            state_n    = S_IDLE;
         end
         S_DROP: if (mem.mem_rsp_v) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // A redirect overrides everything; an accepted but unanswered request must be drained.
      if (mdfy_pc) begin
         clr        = 1'b1;
         wr_n       = '0;
         fetch_pc_n = {pc[31:2], 2'b00};
         case (state)
            S_REQ:   state_n = mem.mem_req_rdy ? S_DROP : S_IDLE;
            S_WAIT:  state_n = mem.mem_rsp_v ? S_IDLE : S_DROP;
            S_DROP:  state_n = mem.mem_rsp_v ? S_IDLE : S_DROP;
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge cclk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         fetch_pc <= '0;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
      end
   end

   ifq_ring_buffer #(.QUEUE_LEN(QUEUE_LEN)) u_ring (
      .clk     (cclk),
      .rst     (rst),
      .clr     (clr),
      .wr_n    (wr_n),
      .wr_data (wr_data),
      .pop     (pop),
      .head    (head),
      .count   (count),
      .free    (free)
   );

`ifdef IFQ_PERF_CNT_EN
   always_ff @(posedge cclk or negedge rst) begin
      if (!rst) begin
         perf_flush_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (mdfy_pc)    perf_flush_cnt <= perf_flush_cnt + 32'd1;
         if (!inst_pres) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue; memory side driven by hand through the interface.
module tb_instruction_fetch_queue;
   logic        cclk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc = '0;
   logic        mdfy_pc = 1'b0;
   logic [63:0] curr_inst;
   logic        inst_pres;
   logic        rq_nxt_inst = 1'b0;
`ifdef IFQ_PERF_CNT_EN
   logic [31:0] perf_flush_cnt;
   logic [31:0] perf_stall_cnt;
`endif
   int n_checks = 0;
   int n_fail   = 0;

   instruction_fetch_queue_if mem_bus();

   instruction_fetch_queue #(.QUEUE_LEN(16)) dut (
      .cclk           (cclk),
      .rst            (rst),
      .pc             (pc),
      .mdfy_pc        (mdfy_pc),
      .curr_inst      (curr_inst),
      .inst_pres      (inst_pres),
      .rq_nxt_inst    (rq_nxt_inst),
`ifdef IFQ_PERF_CNT_EN
      .perf_flush_cnt (perf_flush_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .mem            (mem_bus)
   );

   always #5 cclk = ~cclk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [63:0] entry(input logic [31:0] a);
      return {a, inst_of(a)};
   endfunction

   function automatic logic [255:0] line_data(input logic [31:0] line);
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = inst_of(line + 32'(4 * i));
      return d;
   endfunction

   // Waits (bounded) for a request, accepts it for one cycle, returns its address.
   task automatic mem_accept(output logic [31:0] addr, output bit ok);
      ok = 0;
      addr = '0;
      for (int i = 0; i < 50; i++) begin
         if (mem_bus.mem_req_v) begin
            addr = mem_bus.mem_req_addr;
            mem_bus.mem_req_rdy = 1'b1;
            @(negedge cclk);
            mem_bus.mem_req_rdy = 1'b0;
            ok = 1;
            return;
         end
         @(negedge cclk);
      end
   endtask

   task automatic mem_respond(input logic [31:0] line);
      mem_bus.mem_rsp_v   = 1'b1;
      mem_bus.mem_rsp_dat = line_data(line);
      @(negedge cclk);
      mem_bus.mem_rsp_v   = 1'b0;
   endtask

   task automatic pop_one(output logic [63:0] v);
      v = curr_inst;
      rq_nxt_inst = 1'b1;
      @(negedge cclk);
      rq_nxt_inst = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      mdfy_pc = 1'b1;
      pc      = target;
      @(negedge cclk);
      mdfy_pc = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      mem_bus.mem_req_rdy = 1'b0;
      mem_bus.mem_rsp_v   = 1'b0;
      mem_bus.mem_rsp_dat = '0;
      repeat (3) @(negedge cclk);
      n_checks++;
      if (inst_pres !== 1'b0) begin n_fail++; $display("FAIL reset_inst_pres: got %b want 0", inst_pres); end
      n_checks++;
      if (curr_inst !== 64'h0) begin n_fail++; $display("FAIL reset_curr_inst: got %h want 0", curr_inst); end
      n_checks++;
      if (mem_bus.mem_req_v !== 1'b0) begin n_fail++; $display("FAIL reset_req_v: got %b want 0", mem_bus.mem_req_v); end
      n_checks++;
      if (mem_bus.mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h want 0", mem_bus.mem_req_addr); end
   endtask

   task automatic test_line_fetch;
      logic [31:0] a;
      logic [63:0] v;
      bit ok;
      rst = 1'b1;
      redirect(32'h100);
      mem_accept(a, ok);
      n_checks++;
      if (!ok || a !== 32'h100) begin n_fail++; $display("FAIL line_req_addr: got %h ok=%0d want 00000100", a, ok); end
      mem_respond(32'h100);
      n_checks++;
      if (inst_pres !== 1'b1) begin n_fail++; $display("FAIL line_inst_pres: got %b want 1", inst_pres); end
      for (int i = 0; i < 8; i++) begin
         pop_one(v);
         n_checks++;
         if (v !== entry(32'h100 + 32'(4 * i)))
            begin n_fail++; $display("FAIL line_word%0d: got %h want %h", i, v, entry(32'h100 + 32'(4 * i))); end
      end
      n_checks++;
      if (inst_pres !== 1'b0) begin n_fail++; $display("FAIL line_empty: got %b want 0", inst_pres); end
   endtask

   task automatic test_redirect_mid_line;
      logic [31:0] a;
      logic [63:0] v;
      bit ok;
      redirect(32'h116);
      n_checks++;
      if (mem_bus.mem_req_v !== 1'b0) begin n_fail++; $display("FAIL redir_withdraw: got %b want 0", mem_bus.mem_req_v); end
      mem_accept(a, ok);
      n_checks++;
      if (!ok || a !== 32'h100) begin n_fail++; $display("FAIL redir_req_addr: got %h want 00000100", a); end
      mem_respond(32'h100);
      for (int i = 0; i < 3; i++) begin
         pop_one(v);
         n_checks++;
         if (v !== entry(32'h114 + 32'(4 * i)))
            begin n_fail++; $display("FAIL redir_word%0d: got %h want %h", i, v, entry(32'h114 + 32'(4 * i))); end
      end
      n_checks++;
      if (inst_pres !== 1'b0) begin n_fail++; $display("FAIL redir_count3: got %b want 0", inst_pres); end
      mem_accept(a, ok);
      n_checks++;
      if (!ok || a !== 32'h120) begin n_fail++; $display("FAIL redir_next_addr: got %h want 00000120", a); end
   endtask

   task automatic test_flush_drop;
      logic [31:0] a;
      bit ok;
      redirect(32'h400);
      n_checks++;
      if (inst_pres !== 1'b0 || mem_bus.mem_req_v !== 1'b0)
         begin n_fail++; $display("FAIL drop_after_flush: got pres=%b req=%b want 0 0", inst_pres, mem_bus.mem_req_v); end
      mem_respond(32'h120);
      n_checks++;
      if (inst_pres !== 1'b0) begin n_fail++; $display("FAIL drop_discard: got %b want 0", inst_pres); end
      mem_accept(a, ok);
      n_checks++;
      if (!ok || a !== 32'h400) begin n_fail++; $display("FAIL drop_req_addr: got %h want 00000400", a); end
      mem_respond(32'h400);
      n_checks++;
      if (curr_inst !== entry(32'h400)) begin n_fail++; $display("FAIL drop_first: got %h want %h", curr_inst, entry(32'h400)); end
`ifdef IFQ_PERF_CNT_EN
      n_checks++;
      if (perf_flush_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_flush: got %0d want 3", perf_flush_cnt); end
`endif
   endtask

   task automatic test_fill;
      logic [31:0] a;
      logic [63:0] v;
      bit ok;
      bit seen;
      mem_accept(a, ok);
      n_checks++;
      if (!ok || a !== 32'h420) begin n_fail++; $display("FAIL fill_req2: got %h want 00000420", a); end
      mem_respond(32'h420);
      seen = 0;
      repeat (10) begin
         if (mem_bus.mem_req_v) seen = 1;
         @(negedge cclk);
      end
      for (int i = 0; i < 7; i++) begin
         pop_one(v);
         n_checks++;
         if (v !== entry(32'h400 + 32'(4 * i)))
            begin n_fail++; $display("FAIL fill_word%0d: got %h want %h", i, v, entry(32'h400 + 32'(4 * i))); end
      end
      repeat (5) begin
         if (mem_bus.mem_req_v) seen = 1;
         @(negedge cclk);
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL fill_no_req: got %b want 0", seen); end
      pop_one(v);
      mem_accept(a, ok);
      n_checks++;
      if (!ok || a !== 32'h440) begin n_fail++; $display("FAIL fill_req3: got %h ok=%0d want 00000440", a, ok); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] v;
      for (int i = 0; i < 7; i++) pop_one(v);
      n_checks++;
      if (curr_inst !== entry(32'h43C)) begin n_fail++; $display("FAIL b2b_last: got %h want %h", curr_inst, entry(32'h43C)); end
      rq_nxt_inst = 1'b1;
      mem_respond(32'h440);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (inst_pres !== 1'b1 || curr_inst !== entry(32'h440 + 32'(4 * i)))
            begin n_fail++; $display("FAIL b2b_word%0d: got %b/%h want 1/%h", i, inst_pres, curr_inst, entry(32'h440 + 32'(4 * i))); end
         @(negedge cclk);
      end
      rq_nxt_inst = 1'b0;
      n_checks++;
      if (inst_pres !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", inst_pres); end
   endtask

   task automatic test_reset_midop;
      bit seen;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (mem_bus.mem_req_v) seen = 1;
         else @(negedge cclk);
      end
      n_checks++;
      if (!seen || mem_bus.mem_req_addr !== 32'h460)
         begin n_fail++; $display("FAIL rstmid_req: got %b/%h want 1/00000460", seen, mem_bus.mem_req_addr); end
      rst = 1'b0;
      #1;
      n_checks++;
      if (mem_bus.mem_req_v !== 1'b0 || mem_bus.mem_req_addr !== 32'h0 || inst_pres !== 1'b0 || curr_inst !== 64'h0)
         begin n_fail++; $display("FAIL rstmid_outputs: got %b %h %b %h want all 0", mem_bus.mem_req_v, mem_bus.mem_req_addr, inst_pres, curr_inst); end
      repeat (2) @(negedge cclk);
      rst = 1'b1;
      mem_respond(32'h460);
      n_checks++;
      if (inst_pres !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_rsp: got %b want 0", inst_pres); end
      n_checks++;
      if (mem_bus.mem_req_v !== 1'b1 || mem_bus.mem_req_addr !== 32'h0)
         begin n_fail++; $display("FAIL rstmid_refetch: got %b/%h want 1/00000000", mem_bus.mem_req_v, mem_bus.mem_req_addr); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(negedge cclk);
      test_reset();
      test_line_fetch();
      test_redirect_mid_line();
      test_flush_drop();
      test_fill();
      test_back_to_back();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
